// File: rtl/condlogic_stage.sv
// condlogic_stage
//   Execute-stage condition check and flag register for a pipelined
//   ARM-style core. The condition field of the Execute instruction is
//   evaluated against the architectural flags. The instruction "commits"
//   only when its condition passes and the stage is neither stalled nor
//   flushed. A committing instruction may update the N/Z and/or C/V
//   halves of the flag register, and its side-effecting controls are
//   registered into the Memory stage.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   CondE         condition field of the Execute instruction
//   ALUFlags      {N,Z,C,V} produced by the ALU for that instruction
//   FlagWriteE    [1] update N,Z ; [0] update C,V
//   PCSrcE, RegWriteE, MemWriteE, NoWriteE   raw decoder controls
//   StallE        Execute held this cycle (bubble into Memory)
//   FlushE        Execute instruction killed this cycle
//   Flags         architectural {N,Z,C,V}
//   CondExE       combinational condition-pass
//   PCSrcM, RegWriteM, MemWriteM   gated controls in the Memory stage
module condlogic_stage #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] CondE,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWriteE,
    input  logic       PCSrcE,
    input  logic       RegWriteE,
    input  logic       MemWriteE,
    input  logic       NoWriteE,
    input  logic       StallE,
    input  logic       FlushE,
    output logic [3:0] Flags,
    output logic       CondExE,
    output logic       PCSrcM,
    output logic       RegWriteM,
    output logic       MemWriteM
);

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memwrite;
    } mctrl_t;

    logic   n, z, c, v;
    logic   commit;
    mctrl_t mctrl_d, mctrl_q;

    assign {n, z, c, v} = Flags;

    // Condition uses the registered flags, so a flag-setting instruction
    // affects the following instruction one cycle later.
    always_comb begin
        CondExE = 1'b0;
        case (CondE)
            4'b0000: CondExE = z;
            4'b0001: CondExE = ~z;
            4'b0010: CondExE = c;
            4'b0011: CondExE = ~c;
            4'b0100: CondExE = n;
            4'b0101: CondExE = ~n;
            4'b0110: CondExE = v;
            4'b0111: CondExE = ~v;
            4'b1000: CondExE = c & ~z;
            4'b1001: CondExE = ~c | z;
            4'b1010: CondExE = ~(n ^ v);
            4'b1011: CondExE = n ^ v;
            4'b1100: CondExE = ~z & ~(n ^ v);
            4'b1101: CondExE = z | (n ^ v);
            4'b1110: CondExE = 1'b1;
            default: CondExE = 1'b0;
        endcase
    end

    // Stall and flush both turn the instruction into a bubble.
    assign commit = CondExE & ~StallE & ~FlushE;

    always_comb begin
        mctrl_d          = '0;
        mctrl_d.pcsrc    = PCSrcE & commit;
        mctrl_d.regwrite = RegWriteE & ~NoWriteE & commit;
        mctrl_d.memwrite = MemWriteE & commit;
    end

    // N/Z and C/V halves carry separate enables so an instruction can
    // update either or both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Flags <= FLAG_RESET;
        end else begin
            if (commit && FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
            if (commit && FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mctrl_q <= '0;
        else        mctrl_q <= mctrl_d;
    end

    assign PCSrcM    = mctrl_q.pcsrc;
    assign RegWriteM = mctrl_q.regwrite;
    assign MemWriteM = mctrl_q.memwrite;

endmodule

// File: tb/tb_condlogic_stage.sv
module tb_condlogic_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] CondE, ALUFlags;
    logic [1:0] FlagWriteE;
    logic       PCSrcE, RegWriteE, MemWriteE, NoWriteE, StallE, FlushE;
    logic [3:0] Flags;
    logic       CondExE, PCSrcM, RegWriteM, MemWriteM;

    condlogic_stage #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .CondE(CondE), .ALUFlags(ALUFlags),
        .FlagWriteE(FlagWriteE), .PCSrcE(PCSrcE), .RegWriteE(RegWriteE),
        .MemWriteE(MemWriteE), .NoWriteE(NoWriteE), .StallE(StallE),
        .FlushE(FlushE), .Flags(Flags), .CondExE(CondExE), .PCSrcM(PCSrcM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM)
    );

    always #5 clk = ~clk;

    // stimulus + expected results; m = {pcsrc, regwrite, memwrite}
    typedef struct {
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic       pc, rw, mw, nw, st, fl;
        logic       exp_cx;
        logic [2:0] exp_m;
        logic [3:0] exp_f;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] m;
        logic [3:0] f;
    } exp_t;

    vec_t vecs[14];
    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic [3:0] cond, logic [3:0] alu, logic [1:0] fw,
                                logic pc, logic rw, logic mw, logic nw, logic st,
                                logic fl, logic cx, logic [2:0] m, logic [3:0] f);
        vec_t r;
        r.cond = cond; r.alu = alu; r.fw = fw;
        r.pc = pc; r.rw = rw; r.mw = mw; r.nw = nw; r.st = st; r.fl = fl;
        r.exp_cx = cx; r.exp_m = m; r.exp_f = f;
        return r;
    endfunction

    // Reference condition: base test per pair of codes, odd code inverts.
    function automatic logic cond_model(logic [3:0] cc, logic [3:0] f);
        logic fn, fz, fc, fv, base;
        {fn, fz, fc, fv} = f;
        base = 1'b0;
        case (cc[3:1])
            3'd0: base = fz;
            3'd1: base = fc;
            3'd2: base = fn;
            3'd3: base = fv;
            3'd4: base = fc && !fz;
            3'd5: base = (fn == fv);
            3'd6: base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        CondE = t.cond; ALUFlags = t.alu; FlagWriteE = t.fw;
        PCSrcE = t.pc; RegWriteE = t.rw; MemWriteE = t.mw; NoWriteE = t.nw;
        StallE = t.st; FlushE = t.fl;
    endtask

    task automatic chk_all_clear(input string name);
        chk({name, " flags"}, {4'h0, Flags}, 8'h00);
        chk({name, " m"}, {5'h0, PCSrcM, RegWriteM, MemWriteM}, 8'h00);
    endtask

    initial begin
        exp_t e;
        vec_t t;
        //            cond     alu      fw     pc rw mw nw st fl cx  m       f
        vecs[0]  = mk(4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 1, 3'b010, 4'b0000);
        vecs[1]  = mk(4'b0000, 4'b0100, 2'b11, 0, 1, 1, 0, 0, 0, 0, 3'b000, 4'b0000);
        vecs[2]  = mk(4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b1100);
        vecs[3]  = mk(4'b0000, 4'b1111, 2'b00, 1, 0, 0, 0, 0, 0, 1, 3'b100, 4'b1100);
        vecs[4]  = mk(4'b1110, 4'b1001, 2'b11, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b1001);
        vecs[5]  = mk(4'b1100, 4'b0000, 2'b11, 0, 0, 1, 0, 1, 0, 1, 3'b000, 4'b1001);
        vecs[6]  = mk(4'b1100, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0, 1, 3'b001, 4'b1001);
        vecs[7]  = mk(4'b1110, 4'b0011, 2'b01, 1, 1, 0, 0, 0, 1, 1, 3'b000, 4'b1001);
        vecs[8]  = mk(4'b1111, 4'b0110, 2'b11, 1, 1, 1, 0, 0, 0, 0, 3'b000, 4'b1001);
        vecs[9]  = mk(4'b1110, 4'b0000, 2'b00, 0, 1, 1, 1, 0, 0, 1, 3'b001, 4'b1001);
        vecs[10] = mk(4'b1110, 4'b0110, 2'b01, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b1010);
        vecs[11] = mk(4'b1011, 4'b0101, 2'b11, 0, 1, 0, 0, 0, 0, 1, 3'b010, 4'b0101);
        vecs[12] = mk(4'b1001, 4'b1111, 2'b10, 1, 0, 0, 0, 0, 0, 1, 3'b100, 4'b1101);
        vecs[13] = mk(4'b1110, 4'b0000, 2'b11, 1, 1, 1, 0, 1, 1, 1, 3'b000, 4'b1101);

        drive(mk(4'b1111, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'h0));
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all_clear("reset");
        @(negedge clk) rst_n = 1'b1;

        // table: condition checked combinationally, M/flags checked after the edge
        for (int i = 0; i < 14; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1 chk($sformatf("v%0d condex", i), {7'h0, CondExE}, {7'h0, vecs[i].exp_cx});
            e.idx = i; e.m = vecs[i].exp_m; e.f = vecs[i].exp_f;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            if (sbq.size() == 0) begin
                chk("scoreboard empty", 8'h01, 8'h00);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("v%0d m", e.idx), {5'h0, PCSrcM, RegWriteM, MemWriteM}, {5'h0, e.m});
                chk($sformatf("v%0d flags", e.idx), {4'h0, Flags}, {4'h0, e.f});
            end
        end

        // full condition sweep over every flag value
        for (int f = 0; f < 16; f++) begin
            @(negedge clk);
            t = mk(4'b1110, 4'(f), 2'b11, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'(f));
            drive(t);
            @(posedge clk);
            #1 chk($sformatf("load f%0d", f), {4'h0, Flags}, {4'h0, 4'(f)});
            FlagWriteE = 2'b00;
            for (int c = 0; c < 16; c++) begin
                CondE = 4'(c);
                #1 chk($sformatf("sweep c%0d f%0d", c, f), {7'h0, CondExE},
                       {7'h0, cond_model(4'(c), 4'(f))});
            end
        end

        // asynchronous reset between edges, then held across an edge
        @(negedge clk);
        drive(mk(4'b1110, 4'b1011, 2'b11, 0, 1, 0, 0, 0, 0, 1, 3'b010, 4'b1011));
        @(posedge clk);
        #1 chk("pre-reset rw", {7'h0, RegWriteM}, 8'h01);
        chk("pre-reset flags", {4'h0, Flags}, 8'h0b);
        #2 rst_n = 1'b0;
        #1 chk_all_clear("async reset");
        @(posedge clk);
        #1 chk_all_clear("reset held edge");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("post-reset rw", {7'h0, RegWriteM}, 8'h01);
        chk("post-reset flags", {4'h0, Flags}, 8'h0b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/condlogic_stage.md
CONDLOGIC_STAGE -- requirements
Module: condlogic_stage

Interface
REQ-001 Parameter: FLAG_RESET, 4'b0000, reset value of the {N,Z,C,V} flag register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 CondE  input  4  condition field of the Execute-stage instruction.
REQ-005 ALUFlags  input  4  {N,Z,C,V} produced by the ALU for the Execute-stage instruction.
REQ-006 FlagWriteE  input  2  [1] = update N,Z; [0] = update C,V.
REQ-007 PCSrcE, RegWriteE, MemWriteE, NoWriteE  input  1 each  raw decoder controls of the Execute-stage instruction.
REQ-008 StallE  input  1  Execute stage held this cycle.
REQ-009 FlushE  input  1  Execute-stage instruction killed this cycle.
REQ-010 Flags  output  4  current architectural flag register {N,Z,C,V}.
REQ-011 CondExE  output  1  condition-pass of the Execute-stage instruction (combinational).
REQ-012 PCSrcM, RegWriteM, MemWriteM  output  1 each  gated controls registered into the Memory stage.

Function
REQ-013 CondExE SHALL be evaluated combinationally from CondE and the registered Flags (not ALUFlags).
REQ-014 Encoding SHALL be: 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V; 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-015 Commit = CondExE & ~StallE & ~FlushE.
REQ-016 On a clock edge with Commit & FlagWriteE[1], Flags[3:2] SHALL load ALUFlags[3:2]; otherwise hold.
REQ-017 On a clock edge with Commit & FlagWriteE[0], Flags[1:0] SHALL load ALUFlags[1:0]; otherwise hold.
REQ-018 NZ and CV halves SHALL update independently in the same cycle.
REQ-019 Flag update latency: one cycle; the next instruction's CondExE SHALL see the new flags.
REQ-020 PCSrcM SHALL register PCSrcE & Commit.
REQ-021 RegWriteM SHALL register RegWriteE & ~NoWriteE & Commit.
REQ-022 MemWriteM SHALL register MemWriteE & Commit.
REQ-023 StallE=1 SHALL insert a bubble: M outputs load 0, Flags hold.
REQ-024 FlushE=1 SHALL have priority equal to StallE: M outputs load 0, Flags hold.
REQ-025 Cond=1111 SHALL never commit; no flag or control side effect.
REQ-026 ALUFlags SHALL be ignored whenever FlagWriteE=00.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force Flags=FLAG_RESET and PCSrcM=RegWriteM=MemWriteM=0.
REQ-028 Reset asserted mid-operation SHALL discard any pending update; no flag or control write on the edge coinciding with reset.
REQ-029 After rst_n deasserts, the first rising edge SHALL behave per REQ-015..REQ-024.

Verification
REQ-030 Reset, CondE=1110, RegWriteE=1 -> CondExE=1, next edge RegWriteM=1, Flags=0000.
REQ-031 Flags=0000, CondE=0000, FlagWriteE=11, ALUFlags=0100 -> CondExE=0, Flags stay 0000, M outputs 0.
REQ-032 CondE=1110, FlagWriteE=10, ALUFlags=1111 then next CondE=0000 -> Flags=1100, second CondExE=1.
REQ-033 Flags=1001 (N=1,V=1), CondE=1100, MemWriteE=1, StallE=1 -> CondExE=1, MemWriteM=0, Flags unchanged; release stall -> MemWriteM=1.
REQ-034 CondE=1110, FlagWriteE=01, ALUFlags=0011, FlushE=1 -> Flags unchanged, all M outputs 0.
REQ-035 All 16 CondE codes x 16 Flags values -> CondExE matches REQ-014; rst_n pulsed between edges -> outputs clear without clk.
